// File: rtl/can_pkg.sv
// Shared constants and FSM encoding for the CAN frame transmitter.
package can_pkg;

    localparam logic CAN_RECESSIVE = 1'b1;
    localparam logic CAN_DOMINANT  = 1'b0;

    localparam int STUFF_LIMIT = 5;
    localparam int EOF_BITS    = 7;
    localparam int IFS_BITS    = 3;
    localparam int FRAME_WIDTH = 108;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        DATA,
        EOF,
        IFS
    } can_state_e;

endpackage

// File: rtl/can_bit_tick.sv
// Bit period timer: counts 0..BIT_TICKS-1 while enabled, tick on the last cycle of each period.
module can_bit_tick #(
    parameter int BIT_TICKS = 50
) (
    input  logic GCLK,
    input  logic RES,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(BIT_TICKS);
    localparam logic [CW-1:0] LAST = CW'(BIT_TICKS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge GCLK or posedge RES) begin
        if (RES) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/can_frame_tx.sv
// Pops one frame word from a queue and serialises it MSB first with bit stuffing,
// followed by the end-of-frame and interframe recessive bits.
module can_frame_tx
    import can_pkg::*;
#(
    parameter int WIDTH     = FRAME_WIDTH,
    parameter int BIT_TICKS = 50
) (
    input  logic             GCLK,
    input  logic             RES,
    input  logic             q_empty,
    output logic             q_get,
    input  logic [WIDTH-1:0] q_dout,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int DW = $clog2(WIDTH + 1);

    can_state_e       state, state_nxt;
    logic             tick, tick_en;
    logic [WIDTH-1:0] shreg;
    logic             cur_bit;
    logic [DW-1:0]    data_cnt;
    logic [2:0]       run_cnt;
    logic [2:0]       seg_cnt;
    logic             stuff_due, data_last, seg_last;

    // run_cnt is the length of the equal-bit run ending with the bit now on the line
    assign stuff_due = (run_cnt == 3'(STUFF_LIMIT));
    assign data_last = (data_cnt == DW'(WIDTH));
    assign seg_last  = (state == EOF) ? (seg_cnt == 3'(EOF_BITS - 1))
                                      : (seg_cnt == 3'(IFS_BITS - 1));
    assign tick_en   = (state == DATA) || (state == EOF) || (state == IFS);

    can_bit_tick #(
        .BIT_TICKS(BIT_TICKS)
    ) u_bit_tick (
        .GCLK(GCLK),
        .RES (RES),
        .en  (tick_en),
        .tick(tick)
    );

    always_ff @(posedge GCLK or posedge RES) begin
        if (RES) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_get     = 1'b0;
        tx        = CAN_RECESSIVE;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // RES gate keeps the pop request quiet while reset is held
                if (!q_empty && !RES) begin
                    q_get     = 1'b1;
                    state_nxt = POP;
                end
            end
            POP:  state_nxt = LOAD;
            LOAD: state_nxt = DATA;
            DATA: begin
                tx = cur_bit;
                if (tick && !stuff_due && data_last) begin
                    state_nxt = EOF;
                end
            end
            EOF: begin
                if (tick && seg_last) begin
                    state_nxt = IFS;
                end
            end
            IFS: begin
                if (tick && seg_last) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE) || q_get;

    always_ff @(posedge GCLK or posedge RES) begin
        if (RES) begin
            data_cnt <= '0;
            run_cnt  <= '0;
            seg_cnt  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    data_cnt <= DW'(1);
                    run_cnt  <= 3'd1;
                    seg_cnt  <= '0;
                end
                DATA: begin
                    if (tick) begin
                        if (stuff_due) begin
                            run_cnt <= 3'd1;
                        end else if (!data_last) begin
                            data_cnt <= data_cnt + 1'b1;
                            run_cnt  <= (shreg[WIDTH-1] == cur_bit) ? run_cnt + 3'd1 : 3'd1;
                        end
                    end
                end
                EOF, IFS: begin
                    if (tick) begin
                        seg_cnt <= seg_last ? 3'd0 : seg_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame payload; only meaningful in DATA, so it carries no reset
    always_ff @(posedge GCLK) begin
        if (state == LOAD) begin
            cur_bit <= q_dout[WIDTH-1];
            shreg   <= q_dout << 1;
        end else if (state == DATA && tick) begin
            if (stuff_due) begin
                cur_bit <= ~cur_bit;
            end else if (!data_last) begin
                cur_bit <= shreg[WIDTH-1];
                shreg   <= shreg << 1;
            end
        end
    end

endmodule

// File: tb/tb_can_frame_tx.sv
// Directed bench for can_frame_tx with an 8-bit frame and 4 clocks per bit.
module tb_can_frame_tx;

    localparam int WIDTH     = 8;
    localparam int BIT_TICKS = 4;

    logic             GCLK    = 1'b0;
    logic             RES     = 1'b1;
    logic             q_empty = 1'b0;
    logic [WIDTH-1:0] q_dout  = 8'hA5;
    logic             q_get, tx, busy, done;

    int vectors = 0;
    int errors  = 0;

    always #5 GCLK = ~GCLK;

    can_frame_tx #(
        .WIDTH    (WIDTH),
        .BIT_TICKS(BIT_TICKS)
    ) dut (
        .GCLK   (GCLK),
        .RES    (RES),
        .q_empty(q_empty),
        .q_get  (q_get),
        .q_dout (q_dout),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    // Reset held with a non-empty queue: outputs idle, no pop
    task automatic test_reset;
        logic [3:0] got;
        for (int i = 0; i < 3; i++) begin
            @(negedge GCLK);
            got = {q_get, busy, tx, done};
            vectors++;
            if (got !== 4'b0010) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: {q_get,busy,tx,done}=%b want 0010", i, got);
            end
        end
        @(posedge GCLK); #1;
        q_empty = 1'b1;
        RES     = 1'b0;
        @(negedge GCLK);
        got = {q_get, busy, tx, done};
        vectors++;
        if (got !== 4'b0010) begin
            errors++;
            $display("FAIL reset_release: {q_get,busy,tx,done}=%b want 0010", got);
        end
        @(posedge GCLK); #1;
    endtask

    task automatic test_idle_empty;
        logic [3:0] got;
        q_empty = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge GCLK);
            got = {q_get, busy, tx, done};
            vectors++;
            if (got !== 4'b0010) begin
                errors++;
                $display("FAIL idle_empty cycle %0d: {q_get,busy,tx,done}=%b want 0010", i, got);
            end
            @(posedge GCLK); #1;
        end
    endtask

    // Single frames: plain, all-zero (stuff in the middle), stuff followed by ones
    task automatic test_frames;
        logic [7:0] pat [3] = '{8'hA5, 8'h00, 8'h07};
        string      seq [3] = '{"10100101", "000001000", "000001111"};
        for (int t = 0; t < 3; t++) begin
            int         n;
            int         len;
            logic [3:0] exp;
            logic [3:0] got;
            n       = seq[t].len();
            len     = 3 + BIT_TICKS * n + BIT_TICKS * 10;
            q_dout  = pat[t];
            q_empty = 1'b0;
            for (int i = 0; i <= len; i++) begin
                @(negedge GCLK);
                exp[3] = (i == 0);
                exp[2] = (i < len);
                exp[1] = (i >= 3 && i < 3 + BIT_TICKS * n) ?
                         (seq[t][(i - 3) / BIT_TICKS] == "1") : 1'b1;
                exp[0] = (i == len - 1);
                got    = {q_get, busy, tx, done};
                vectors++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL frame_%h cycle %0d: {q_get,busy,tx,done}=%b want %b",
                             pat[t], i, got, exp);
                end
                @(posedge GCLK); #1;
                if (i == 0) q_empty = 1'b1;
            end
        end
    endtask

    task automatic test_back_to_back;
        int   qg_cnt   = 0;
        int   adjacent = 0;
        int   qg2      = -1;
        int   d1       = -1;
        int   d2       = -1;
        int   busy_low = 0;
        logic prev     = 1'b0;
        q_dout  = 8'hA5;
        q_empty = 1'b0;
        for (int i = 0; i < 170; i++) begin
            @(negedge GCLK);
            if (q_get) begin
                if (prev) adjacent++;
                qg_cnt++;
                if (qg_cnt == 2) qg2 = i;
            end
            if (done) begin
                if (d1 < 0) d1 = i;
                else d2 = i;
            end
            if (i < 150 && !busy) busy_low++;
            prev = q_get;
            @(posedge GCLK); #1;
            if (qg_cnt == 2) q_empty = 1'b1;
        end
        vectors++;
        if (qg_cnt !== 2) begin
            errors++;
            $display("FAIL b2b_pop_count: got %0d pops want 2", qg_cnt);
        end
        vectors++;
        if (adjacent !== 0) begin
            errors++;
            $display("FAIL b2b_adjacent_pops: got %0d want 0", adjacent);
        end
        vectors++;
        if (d1 !== 74) begin
            errors++;
            $display("FAIL b2b_first_done: cycle %0d want 74", d1);
        end
        vectors++;
        if (qg2 !== d1 + 1) begin
            errors++;
            $display("FAIL b2b_second_pop: cycle %0d want %0d", qg2, d1 + 1);
        end
        vectors++;
        if (d2 !== 149) begin
            errors++;
            $display("FAIL b2b_second_done: cycle %0d want 149", d2);
        end
        vectors++;
        if (busy_low !== 0) begin
            errors++;
            $display("FAIL b2b_busy_gap: busy low on %0d cycles want 0", busy_low);
        end
    endtask

    // Reset in the middle of the third data bit of an all-zero frame
    task automatic test_reset_midframe;
        logic [3:0] got;
        q_dout  = 8'h00;
        q_empty = 1'b0;
        @(posedge GCLK); #1;
        q_empty = 1'b1;
        repeat (11) @(posedge GCLK);
        #1;
        vectors++;
        if ({busy, tx} !== 2'b10) begin
            errors++;
            $display("FAIL midframe_before_reset: {busy,tx}=%b want 10", {busy, tx});
        end
        RES = 1'b1;
        #1;
        got = {q_get, busy, tx, done};
        vectors++;
        if (got !== 4'b0010) begin
            errors++;
            $display("FAIL midframe_async_reset: {q_get,busy,tx,done}=%b want 0010", got);
        end
        @(posedge GCLK); #1;
        RES = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge GCLK);
            got = {q_get, busy, tx, done};
            vectors++;
            if (got !== 4'b0010) begin
                errors++;
                $display("FAIL after_midframe_reset cycle %0d: {q_get,busy,tx,done}=%b want 0010",
                         i, got);
            end
            @(posedge GCLK); #1;
        end
    endtask

    initial begin
        test_reset();
        test_idle_empty();
        test_frames();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
